// File: rtl/attack_controller_pkg.sv
// Shared types and constants for the attack path: attack phases, facing, character
// state codes (common with the character and sprite blocks) and damage values.
package attack_controller_pkg;

    typedef enum logic [2:0] {IDLE, WINDUP, ACTIVE, RECOVER, COOLDOWN} phase_t;
    typedef enum logic [1:0] {FACE_FRONT, FACE_BACK, FACE_LEFT, FACE_RIGHT} facing_t;

    localparam logic [3:0] CS_FRONT_IDLE  = 4'h0;
    localparam logic [3:0] CS_FRONT_WALK1 = 4'h1;
    localparam logic [3:0] CS_FRONT_WALK2 = 4'h2;
    localparam logic [3:0] CS_RIGHT_IDLE  = 4'h3;
    localparam logic [3:0] CS_RIGHT_WALK  = 4'h4;
    localparam logic [3:0] CS_LEFT_IDLE   = 4'h5;
    localparam logic [3:0] CS_LEFT_WALK   = 4'h6;
    localparam logic [3:0] CS_BACK_IDLE   = 4'h7;
    localparam logic [3:0] CS_BACK_WALK1  = 4'h8;
    localparam logic [3:0] CS_BACK_WALK2  = 4'h9;
    localparam logic [3:0] CS_FRONT_ATK   = 4'hA;
    localparam logic [3:0] CS_BACK_ATK    = 4'hB;
    localparam logic [3:0] CS_LEFT_ATK    = 4'hC;
    localparam logic [3:0] CS_RIGHT_ATK   = 4'hD;
    localparam logic [3:0] CS_BLANK       = 4'hF;

    localparam logic [1:0] DMG_NONE  = 2'd0;
    localparam logic [1:0] DMG_LIGHT = 2'd1;
    localparam logic [1:0] DMG_HEAVY = 2'd2;

    // Blink/empty (and the unused code E) carry no direction, so the previous facing stands.
    function automatic facing_t facing_decode(input logic [3:0] code, input facing_t prev);
        facing_t f;
        case (code)
            CS_FRONT_IDLE, CS_FRONT_WALK1, CS_FRONT_WALK2, CS_FRONT_ATK: f = FACE_FRONT;
            CS_BACK_IDLE, CS_BACK_WALK1, CS_BACK_WALK2, CS_BACK_ATK:     f = FACE_BACK;
            CS_RIGHT_IDLE, CS_RIGHT_WALK, CS_RIGHT_ATK:                  f = FACE_RIGHT;
            CS_LEFT_IDLE, CS_LEFT_WALK, CS_LEFT_ATK:                     f = FACE_LEFT;
            default:                                                     f = prev;
        endcase
        return f;
    endfunction

    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        logic [9:0] r;
        if (v < 0)
            r = '0;
        else if (v > 12'sd1023)
            r = '1;
        else
            r = v[9:0];
        return r;
    endfunction

endpackage

// File: rtl/attack_controller_hitbox_calc.sv
// Combinational hitbox: square box of half-width HALF_SZ centred REACH pixels from the
// character along its facing axis, bounds saturated to the 10-bit screen range.
module attack_hitbox_calc
    import attack_controller_pkg::*;
#(
    parameter int unsigned REACH   = 20,
    parameter int unsigned HALF_SZ = 8
) (
    input  facing_t     facing,
    input  logic [9:0]  pos_h,
    input  logic [9:0]  pos_v,
    output logic [9:0]  h_lo,
    output logic [9:0]  h_hi,
    output logic [9:0]  v_lo,
    output logic [9:0]  v_hi
);

    localparam logic signed [11:0] REACH_S = 12'(REACH);
    localparam logic signed [11:0] HALF_S  = 12'(HALF_SZ);

    logic signed [11:0] ch;
    logic signed [11:0] cv;

    // BACK is up (+v), FRONT down (-v), LEFT +h, RIGHT -h, as in the character block.
    always_comb begin
        ch = $signed({2'b00, pos_h});
        cv = $signed({2'b00, pos_v});
        case (facing)
            FACE_BACK:  cv = cv + REACH_S;
            FACE_FRONT: cv = cv - REACH_S;
            FACE_LEFT:  ch = ch + REACH_S;
            default:    ch = ch - REACH_S;
        endcase
        h_lo = sat10(ch - HALF_S);
        h_hi = sat10(ch + HALF_S);
        v_lo = sat10(cv - HALF_S);
        v_hi = sat10(cv + HALF_S);
    end

endmodule

// File: rtl/attack_controller.sv
// Attack sequencer: key press -> windup / active hitbox / recover / cooldown.
// Define HEAVY_ATTACK_EN to accept K as a heavy attack (double active and cooldown, damage 2).
module attack_controller
    import attack_controller_pkg::*;
#(
    parameter int unsigned WINDUP_CYC   = 4,
    parameter int unsigned ACTIVE_CYC   = 8,
    parameter int unsigned RECOVER_CYC  = 6,
    parameter int unsigned COOLDOWN_CYC = 16,
    parameter int unsigned REACH        = 20,
    parameter int unsigned HALF_SZ      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        J_signal,
    input  logic        K_signal,
    input  logic        gameover,
    input  logic [3:0]  char_state,
    input  logic [9:0]  pos_h,
    input  logic [9:0]  pos_v,
    output logic        is_attacking,
    output logic        hit_valid,
    output logic [9:0]  hit_h_lo,
    output logic [9:0]  hit_h_hi,
    output logic [9:0]  hit_v_lo,
    output logic [9:0]  hit_v_hi,
    output logic [1:0]  hit_dmg
);

    phase_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        j_prev, press_j_q;
    logic        accept, heavy_sel, cur_heavy, atk_heavy, entered;
    facing_t     seen_dir, atk_dir, dir_sel, calc_dir;
    logic [9:0]  b_h_lo, b_h_hi, b_v_lo, b_v_hi;

`ifdef HEAVY_ATTACK_EN
    logic k_prev, press_k_q;
`else
    logic unused_k;
    assign unused_k = K_signal;
`endif

    function automatic logic [15:0] phase_len(input phase_t p, input logic heavy);
        logic [15:0] n;
        case (p)
            WINDUP:   n = 16'(WINDUP_CYC);
            ACTIVE:   n = heavy ? 16'(2 * ACTIVE_CYC) : 16'(ACTIVE_CYC);
            RECOVER:  n = 16'(RECOVER_CYC);
            COOLDOWN: n = heavy ? 16'(2 * COOLDOWN_CYC) : 16'(COOLDOWN_CYC);
            default:  n = '0;
        endcase
        return n;
    endfunction

    // Walk forward past any zero-length phases; order matters, each test feeds the next.
    function automatic phase_t skip_zero(input phase_t p, input logic heavy);
        phase_t q;
        q = p;
        if (q == WINDUP   && phase_len(q, heavy) == '0) q = ACTIVE;
        if (q == ACTIVE   && phase_len(q, heavy) == '0) q = RECOVER;
        if (q == RECOVER  && phase_len(q, heavy) == '0) q = COOLDOWN;
        if (q == COOLDOWN && phase_len(q, heavy) == '0) q = IDLE;
        return q;
    endfunction

    function automatic phase_t succ(input phase_t p);
        phase_t q;
        case (p)
            WINDUP:  q = ACTIVE;
            ACTIVE:  q = RECOVER;
            RECOVER: q = COOLDOWN;
            default: q = IDLE;
        endcase
        return q;
    endfunction

    always_comb begin
        dir_sel = facing_decode(char_state, seen_dir);
`ifdef HEAVY_ATTACK_EN
        heavy_sel = press_k_q;
        accept    = (state == IDLE) && !gameover && (press_j_q || press_k_q);
`else
        heavy_sel = 1'b0;
        accept    = (state == IDLE) && !gameover && press_j_q;
`endif
        cur_heavy = accept ? heavy_sel : atk_heavy;
        calc_dir  = accept ? dir_sel : atk_dir;

        state_nx = state;
        cnt_nx   = cnt;
        entered  = 1'b0;
        if (gameover) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE) begin
            if (accept) begin
                state_nx = skip_zero(WINDUP, heavy_sel);
                entered  = 1'b1;
            end
        end else if (cnt <= 16'd1) begin
            state_nx = skip_zero(succ(state), atk_heavy);
            entered  = 1'b1;
        end else begin
            cnt_nx = cnt - 16'd1;
        end
        if (entered)
            cnt_nx = phase_len(state_nx, cur_heavy);
    end

    attack_hitbox_calc #(
        .REACH   (REACH),
        .HALF_SZ (HALF_SZ)
    ) u_hitbox (
        .facing (calc_dir),
        .pos_h  (pos_h),
        .pos_v  (pos_v),
        .h_lo   (b_h_lo),
        .h_hi   (b_h_hi),
        .v_lo   (b_v_lo),
        .v_hi   (b_v_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            j_prev       <= 1'b0;
            press_j_q    <= 1'b0;
            seen_dir     <= FACE_FRONT;
            atk_dir      <= FACE_FRONT;
            atk_heavy    <= 1'b0;
            is_attacking <= 1'b0;
            hit_valid    <= 1'b0;
            hit_h_lo     <= '0;
            hit_h_hi     <= '0;
            hit_v_lo     <= '0;
            hit_v_hi     <= '0;
            hit_dmg      <= DMG_NONE;
`ifdef HEAVY_ATTACK_EN
            k_prev       <= 1'b0;
            press_k_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            j_prev    <= J_signal;
            press_j_q <= J_signal & ~j_prev;
            seen_dir  <= dir_sel;
`ifdef HEAVY_ATTACK_EN
            k_prev    <= K_signal;
            press_k_q <= K_signal & ~k_prev;
`endif
            if (accept) begin
                atk_dir   <= dir_sel;
                atk_heavy <= heavy_sel;
            end
            is_attacking <= (state_nx == WINDUP) || (state_nx == ACTIVE) || (state_nx == RECOVER);
            if (state_nx == ACTIVE) begin
                hit_valid <= 1'b1;
                hit_h_lo  <= b_h_lo;
                hit_h_hi  <= b_h_hi;
                hit_v_lo  <= b_v_lo;
                hit_v_hi  <= b_v_hi;
                hit_dmg   <= cur_heavy ? DMG_HEAVY : DMG_LIGHT;
            end else begin
                hit_valid <= 1'b0;
                hit_h_lo  <= '0;
                hit_h_hi  <= '0;
                hit_v_lo  <= '0;
                hit_v_hi  <= '0;
                hit_dmg   <= DMG_NONE;
            end
        end
    end

endmodule

// File: tb/tb_attack_controller.sv
// Scoreboard bench for attack_controller: per-tick expected outputs are queued as each
// stimulus is driven and popped against the DUT one tick at a time.
module tb_attack_controller;

    localparam int WIN = 4;
    localparam int ACT = 8;
    localparam int REC = 6;
    localparam int CD  = 16;

    typedef struct packed {
        logic       att;
        logic       hv;
        logic [9:0] hlo;
        logic [9:0] hhi;
        logic [9:0] vlo;
        logic [9:0] vhi;
        logic [1:0] dmg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       J = 1'b0;
    logic       K = 1'b0;
    logic       gameover = 1'b0;
    logic [3:0] cs = 4'h0;
    logic [9:0] ph = '0;
    logic [9:0] pv = '0;
    logic       is_attacking, hit_valid;
    logic [9:0] hit_h_lo, hit_h_hi, hit_v_lo, hit_v_hi;
    logic [1:0] hit_dmg;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    attack_controller #(
        .WINDUP_CYC   (WIN),
        .ACTIVE_CYC   (ACT),
        .RECOVER_CYC  (REC),
        .COOLDOWN_CYC (CD),
        .REACH        (20),
        .HALF_SZ      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .J_signal     (J),
        .K_signal     (K),
        .gameover     (gameover),
        .char_state   (cs),
        .pos_h        (ph),
        .pos_v        (pv),
        .is_attacking (is_attacking),
        .hit_valid    (hit_valid),
        .hit_h_lo     (hit_h_lo),
        .hit_h_hi     (hit_h_hi),
        .hit_v_lo     (hit_v_lo),
        .hit_v_hi     (hit_v_hi),
        .hit_dmg      (hit_dmg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = '0;
        if (sb.size() > 0)
            e = sb.pop_front();
        check("is_attacking", 32'(is_attacking), 32'(e.att));
        check("hit_valid",    32'(hit_valid),    32'(e.hv));
        check("hit_h_lo",     32'(hit_h_lo),     32'(e.hlo));
        check("hit_h_hi",     32'(hit_h_hi),     32'(e.hhi));
        check("hit_v_lo",     32'(hit_v_lo),     32'(e.vlo));
        check("hit_v_hi",     32'(hit_v_hi),     32'(e.vhi));
        check("hit_dmg",      32'(hit_dmg),      32'(e.dmg));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back('0);
    endtask

    // Expected stream starting with the tick right after the edge that samples the press.
    task automatic push_attack(input logic [9:0] hlo, input logic [9:0] hhi,
                               input logic [9:0] vlo, input logic [9:0] vhi,
                               input logic [1:0] dmg, input int act, input int cd);
        exp_t a, h;
        a = '0;
        a.att = 1'b1;
        h = '0;
        h.att = 1'b1;
        h.hv  = 1'b1;
        h.hlo = hlo;
        h.hhi = hhi;
        h.vlo = vlo;
        h.vhi = vhi;
        h.dmg = dmg;
        sb.push_back('0);
        for (int i = 0; i < WIN; i++) sb.push_back(a);
        for (int i = 0; i < act; i++) sb.push_back(h);
        for (int i = 0; i < REC; i++) sb.push_back(a);
        push_idle(cd);
    endtask

    task automatic drain();
        while (sb.size() > 0)
            tick();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        push_idle(2);
        drain();

        // Single light press facing front, then a press on the last cooldown tick is dropped
        ph = 10'd150; pv = 10'd110; cs = 4'h0;
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        repeat (1 + WIN + ACT + REC + CD - 2) tick();
        J = 1'b1; tick(); J = 1'b0;
        push_idle(1); tick();
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();

        // Held key gives exactly one attack
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        push_idle(65);
        J = 1'b1;
        repeat (100) tick();
        J = 1'b0;
        push_idle(2);
        drain();

        // Second press five ticks into cooldown is ignored
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        push_idle(10);
        J = 1'b1;
        for (int i = 0; i < 45; i++) begin
            J = (i == 0) || (i == 24);
            tick();
        end
        J = 1'b0;
        drain();

        // Facing RIGHT from code D, kept through blink code F; h bounds saturate at 0
        cs = 4'hD; ph = 10'd10; pv = 10'd300;
        push_idle(3);
        drain();
        cs = 4'hF;
        push_attack(10'd0, 10'd0, 10'd292, 10'd308, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();

        // LEFT near the right edge saturates at 1023
        cs = 4'h5; ph = 10'd1015; pv = 10'd40;
        push_attack(10'd1023, 10'd1023, 10'd32, 10'd48, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();

        // BACK
        cs = 4'h8; ph = 10'd500; pv = 10'd600;
        push_attack(10'd492, 10'd508, 10'd612, 10'd628, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();

        // gameover mid-ACTIVE aborts; a press during gameover is dropped
        cs = 4'h0; ph = 10'd150; pv = 10'd110;
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        repeat (7) tick();
        sb.delete();
        gameover = 1'b1;
        push_idle(12);
        for (int i = 0; i < 12; i++) begin
            J = (i == 3);
            tick();
        end
        J = 1'b0;
        gameover = 1'b0;
        push_idle(30);
        drain();

        // Reset mid-RECOVER; facing returns to FRONT so a blink code attacks downward
        cs = 4'h7;
        push_attack(10'd142, 10'd158, 10'd122, 10'd138, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        repeat (14) tick();
        sb.delete();
        rst_n = 1'b0;
        cs = 4'hF;
        push_idle(3);
        drain();
        rst_n = 1'b1;
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();

        // Simultaneous J and K
        cs = 4'h0;
`ifdef HEAVY_ATTACK_EN
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd2, 2 * ACT, 2 * CD);
        J = 1'b1; K = 1'b1; tick(); J = 1'b0; K = 1'b0;
        repeat (1 + WIN + 2 * ACT + REC + 2 * CD - 2) tick();
        J = 1'b1; tick(); J = 1'b0;
        push_idle(1); tick();
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; tick(); J = 1'b0;
        drain();
`else
        push_idle(10);
        K = 1'b1; tick(); K = 1'b0;
        drain();
        push_attack(10'd142, 10'd158, 10'd82, 10'd98, 2'd1, ACT, CD);
        J = 1'b1; K = 1'b1; tick(); J = 1'b0; K = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
